// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns both boards, validates human moves and commits generator moves.
// Define TTT_GAME_CTRL_O_FIRST_EN to let the computer make the opening move.
module ttt_game_ctrl #(
    parameter int unsigned AI_DELAY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_new_game,
    input  logic       i_move_valid,
    input  logic [3:0] i_move_pos,
    output logic       o_move_ready,
    output logic       o_illegal,
    output logic [8:0] o_x_board,
    output logic [8:0] o_o_board,
    input  logic [8:0] i_gen_o,
    output logic       o_x_win,
    output logic       o_o_win,
    output logic       o_draw,
    output logic       o_gen_err,
    output logic [3:0] o_move_count
);

    localparam logic [2:0] ST_WAIT_X  = 3'd0;
    localparam logic [2:0] ST_CHECK_X = 3'd1;
    localparam logic [2:0] ST_THINK   = 3'd2;
    localparam logic [2:0] ST_CHECK_O = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

`ifdef TTT_GAME_CTRL_O_FIRST_EN
    localparam logic [2:0] ST_INIT = ST_THINK;
`else
    localparam logic [2:0] ST_INIT = ST_WAIT_X;
`endif

    logic [2:0] r_state;
    logic [8:0] r_x_board;
    logic [8:0] r_o_board;
    logic [3:0] r_move_count;
    logic [7:0] r_cnt;
    logic       r_illegal;
    logic       r_x_win;
    logic       r_o_win;
    logic       r_draw;
    logic       r_gen_err;

    logic [8:0] w_sel;
    logic       w_legal;
    logic [8:0] w_gen_diff;
    logic       w_gen_ok;
    logic       w_think_last;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Positions 9..15 shift out of the 9-bit one-hot and are rejected by the range check.
    assign w_sel   = 9'b1 << i_move_pos;
    assign w_legal = (i_move_pos <= 4'd8) && ((w_sel & (r_x_board | r_o_board)) == 9'd0);

    // Generator result must be the old O board plus exactly one cell not held by X.
    assign w_gen_diff   = i_gen_o ^ r_o_board;
    assign w_gen_ok     = ((i_gen_o & r_o_board) == r_o_board) &&
                          ((i_gen_o & r_x_board) == 9'd0) &&
                          (w_gen_diff != 9'd0) &&
                          ((w_gen_diff & (w_gen_diff - 9'd1)) == 9'd0);
    assign w_think_last = (r_cnt == 8'(AI_DELAY - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_x_board    <= 9'd0;
            r_o_board    <= 9'd0;
            r_move_count <= 4'd0;
            r_cnt        <= 8'd0;
            r_illegal    <= 1'b0;
            r_x_win      <= 1'b0;
            r_o_win      <= 1'b0;
            r_draw       <= 1'b0;
            r_gen_err    <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (i_new_game) begin
                r_state      <= ST_INIT;
                r_x_board    <= 9'd0;
                r_o_board    <= 9'd0;
                r_move_count <= 4'd0;
                r_cnt        <= 8'd0;
                r_x_win      <= 1'b0;
                r_o_win      <= 1'b0;
                r_draw       <= 1'b0;
                r_gen_err    <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_X: begin
                        if (i_move_valid) begin
                            if (w_legal) begin
                                r_x_board    <= r_x_board | w_sel;
                                r_move_count <= r_move_count + 4'd1;
                                r_state      <= ST_CHECK_X;
                            end else begin
                                r_illegal <= 1'b1;
                            end
                        end
                    end
                    ST_CHECK_X: begin
                        if (has_line(r_x_board)) begin
                            r_x_win <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (r_move_count == 4'd9) begin
                            r_draw  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_THINK;
                        end
                    end
                    ST_THINK: begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_think_last) begin
                            if (w_gen_ok) begin
                                r_o_board    <= i_gen_o;
                                r_move_count <= r_move_count + 4'd1;
                                r_state      <= ST_CHECK_O;
                            end else begin
                                r_gen_err <= 1'b1;
                                r_state   <= ST_DONE;
                            end
                        end
                    end
                    ST_CHECK_O: begin
                        if (has_line(r_o_board)) begin
                            r_o_win <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (r_move_count == 4'd9) begin
                            r_draw  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT_X;
                        end
                    end
                    ST_DONE: ;
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

    assign o_move_ready = (r_state == ST_WAIT_X);
    assign o_illegal    = r_illegal;
    assign o_x_board    = r_x_board;
    assign o_o_board    = r_o_board;
    assign o_x_win      = r_x_win;
    assign o_o_win      = r_o_win;
    assign o_draw       = r_draw;
    assign o_gen_err    = r_gen_err;
    assign o_move_count = r_move_count;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl; gen_o comes from a small priority-list generator.
// Built with TTT_GAME_CTRL_O_FIRST_EN it runs the computer-first scenario instead.
module tb_ttt_game_ctrl;

    localparam int unsigned AI_DELAY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       move_ready;
    logic       illegal;
    logic [8:0] x_board;
    logic [8:0] o_board;
    logic [8:0] gen_o;
    logic       x_win;
    logic       o_win;
    logic       draw;
    logic       gen_err;
    logic [3:0] move_count;

    int gen_mode = 0;
    int n_checks = 0;
    int n_fail   = 0;

    ttt_game_ctrl #(.AI_DELAY(AI_DELAY)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_new_game   (new_game),
        .i_move_valid (move_valid),
        .i_move_pos   (move_pos),
        .o_move_ready (move_ready),
        .o_illegal    (illegal),
        .o_x_board    (x_board),
        .o_o_board    (o_board),
        .i_gen_o      (gen_o),
        .o_x_win      (x_win),
        .o_o_win      (o_win),
        .o_draw       (draw),
        .o_gen_err    (gen_err),
        .o_move_count (move_count)
    );

    always #5 clk = ~clk;

    // Mode 0: center, corners, edges. Mode 1: keep away from the top row.
    // Mode 2: no new mark (faulty). Mode 3: scripted draw cells.
    function automatic logic [8:0] gen_model(input int mode, input logic [8:0] xb,
                                             input logic [8:0] ob);
        int order[9];
        logic [8:0] occ;
        occ = xb | ob;
        case (mode)
            0:       order = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
            1:       order = '{8, 7, 6, 5, 3, 8, 8, 8, 8};
            3:       order = '{4, 1, 5, 6, 4, 4, 4, 4, 4};
            default: return ob;
        endcase
        for (int i = 0; i < 9; i++) begin
            if (!occ[order[i]]) return ob | (9'b1 << order[i]);
        end
        return ob;
    endfunction

    always_comb gen_o = gen_model(gen_mode, x_board, o_board);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] pos);
        move_valid = 1'b1;
        move_pos   = pos;
        tick();
        move_valid = 1'b0;
    endtask

    // Accept, then CHECK_X, AI_DELAY THINK cycles and CHECK_O.
    task automatic play_full(input logic [3:0] pos);
        accept(pos);
        repeat (2 + AI_DELAY) tick();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_x_board", 16'(x_board), 16'h000);
        check("rst_o_board", 16'(o_board), 16'h000);
        check("rst_count", 16'(move_count), 16'd0);
        check("rst_flags", 16'({x_win, o_win, draw, gen_err, illegal}), 16'd0);
`ifdef TTT_GAME_CTRL_O_FIRST_EN
        gen_mode = 0;
        check("ofirst_ready_0", 16'(move_ready), 16'd0);
        tick();
        check("ofirst_o_pending", 16'(o_board), 16'h000);
        tick();
        check("ofirst_o_board", 16'(o_board), 16'h010);
        check("ofirst_count", 16'(move_count), 16'd1);
        check("ofirst_ready_checko", 16'(move_ready), 16'd0);
        tick();
        check("ofirst_ready_1", 16'(move_ready), 16'd1);
`else
        check("rst_ready", 16'(move_ready), 16'd1);

        // First move with the real-style generator
        gen_mode = 0;
        accept(4'd4);
        check("e0_x_board", 16'(x_board), 16'h010);
        check("e0_ready", 16'(move_ready), 16'd0);
        tick();
        tick();
        check("e2_o_pending", 16'(o_board), 16'h000);
        tick();
        check("e3_o_board", 16'(o_board), 16'h001);
        check("e3_count", 16'(move_count), 16'd2);
        check("e3_ready", 16'(move_ready), 16'd0);
        tick();
        check("e4_ready", 16'(move_ready), 16'd1);

        // Illegal offers: occupied by X, out of range, occupied by O
        accept(4'd4);
        check("ill_occ_x_pulse", 16'(illegal), 16'd1);
        check("ill_occ_x_board", 16'(x_board), 16'h010);
        tick();
        check("ill_pulse_end", 16'(illegal), 16'd0);
        accept(4'd9);
        check("ill_range_pulse", 16'(illegal), 16'd1);
        check("ill_range_boards", 16'({x_board, o_board[6:0]}), 16'({9'h010, 7'h01}));
        accept(4'd0);
        check("ill_occ_o_pulse", 16'(illegal), 16'd1);
        check("ill_occ_o_ready", 16'(move_ready), 16'd1);

        // X wins along the top row
        do_new_game();
        check("ng_x_board", 16'(x_board), 16'h000);
        gen_mode = 1;
        play_full(4'd0);
        play_full(4'd1);
        accept(4'd2);
        tick();
        check("xwin_flag", 16'(x_win), 16'd1);
        check("xwin_ready", 16'(move_ready), 16'd0);
        check("xwin_count", 16'(move_count), 16'd5);
        check("xwin_o_board", 16'(o_board), 16'h180);
        accept(4'd5);
        check("done_no_illegal", 16'(illegal), 16'd0);
        check("done_x_board", 16'(x_board), 16'h007);
        check("done_x_win_held", 16'(x_win), 16'd1);

        // Full board with no line
        do_new_game();
        gen_mode = 3;
        play_full(4'd0);
        play_full(4'd2);
        play_full(4'd3);
        play_full(4'd7);
        accept(4'd8);
        tick();
        check("draw_flag", 16'(draw), 16'd1);
        check("draw_count", 16'(move_count), 16'd9);
        check("draw_wins", 16'({x_win, o_win}), 16'd0);
        check("draw_x_board", 16'(x_board), 16'h18D);
        check("draw_o_board", 16'(o_board), 16'h072);
        check("draw_ready", 16'(move_ready), 16'd0);

        // Generator returns no new mark
        do_new_game();
        check("ng_draw_clear", 16'(draw), 16'd0);
        gen_mode = 2;
        accept(4'd4);
        repeat (1 + AI_DELAY) tick();
        check("generr_flag", 16'(gen_err), 16'd1);
        check("generr_o_board", 16'(o_board), 16'h000);
        check("generr_count", 16'(move_count), 16'd1);
        tick();
        check("generr_ready", 16'(move_ready), 16'd0);

        // Reset in the second THINK cycle
        do_new_game();
        gen_mode = 0;
        accept(4'd4);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_think_x", 16'(x_board), 16'h000);
        check("rst_think_o", 16'(o_board), 16'h000);
        tick();
        rst = 1'b0;
        tick();
        check("rst_think_o_after", 16'(o_board), 16'h000);
        check("rst_think_count", 16'(move_count), 16'd0);
        check("rst_think_ready", 16'(move_ready), 16'd1);

        // new_game discards a simultaneous move
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd3;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        check("ng_mv_x_board", 16'(x_board), 16'h000);
        check("ng_mv_ready", 16'(move_ready), 16'd1);
        check("ng_mv_illegal", 16'(illegal), 16'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Sequential game controller that sits directly upstream of the combinational move generator and also consumes its result. It owns the 3×3 board registers: `x_board` (human) and `o_board` (computer). It accepts and validates human moves through a valid/ready handshake and drives both boards into the generator. After a configurable think delay it commits the generator's `newO` back into `o_board`. It detects win and draw after every move and flags generator faults.

## Interface
- `AI_DELAY`, default 2: number of THINK cycles before the O move commits. Legal range is 1..255.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `new_game`, input, 1: synchronous clear of the game. Acts from any state.
- `move_valid`, input, 1: the human offers a move.
- `move_pos`, input, 4: cell index 0..8. Bit i maps to row i/3, column i%3.
- `move_ready`, output, 1: the controller can accept a move.
- `illegal`, output, 1: one-cycle pulse when an offered move is rejected.
- `x_board`, output, 9: X occupancy. Feeds the generator input `x`.
- `o_board`, output, 9: O occupancy. Feeds the generator input `o`.
- `gen_o`, input, 9: the generator's `newO` result, computed combinationally from `x_board`/`o_board`.
- `x_win`, `o_win`, `draw`, output, 1 each: result flags, held in DONE.
- `gen_err`, output, 1: `gen_o` was not `o_board` plus exactly one free cell.
- `move_count`, output, 4: total marks on the board, 0..9.

## Operation
- States: WAIT_X, CHECK_X, THINK, CHECK_O, DONE.
- Reset / `new_game` values:
  - Boards = 0; all flags = 0; `move_count` = 0; THINK counter = 0.
  - State = WAIT_X (THINK when the `_EN` macro is defined).
- WAIT_X:
  - `move_ready`=1.
  - On `move_valid`, the move is legal when `move_pos`≤8 and the cell is empty in both boards.
  - Legal move: set `x_board[move_pos]`, increment `move_count`, go to CHECK_X.
  - Illegal move: assert `illegal` for one cycle, leave the boards unchanged, stay in WAIT_X.
- CHECK_X (1 cycle), evaluated on the registered boards (8 lines):
  - X has a line → set `x_win`, go to DONE.
  - Else `move_count`==9 → set `draw`, go to DONE.
  - Else go to THINK with the counter at 0.
- THINK:
  - The counter increments each cycle.
  - In the cycle where counter==AI_DELAY-1, check `gen_o`.
  - Valid `gen_o` (`gen_o` & `o_board` == `o_board`, `gen_o` & `x_board` == 0, and popcount(`gen_o` ^ `o_board`)==1): `o_board`<=`gen_o`, increment `move_count`, go to CHECK_O.
  - Otherwise: set `gen_err`, go to DONE, leave `o_board` unchanged.
- CHECK_O (1 cycle):
  - O has a line → set `o_win`, go to DONE.
  - Else `move_count`==9 → set `draw`, go to DONE.
  - Else go to WAIT_X.
- DONE:
  - `move_ready`=0.
  - `move_valid` is ignored: no `illegal` pulse is raised.
  - Flags hold until `new_game` or `rst`.
- Priority: `rst` > `new_game` > `move_valid`. A `new_game` in the same cycle as `move_valid` discards the move.
- `move_ready` is 0 in every state except WAIT_X. `move_valid` outside WAIT_X is ignored.

## Timing
- Handshake: a move is accepted at the edge where `move_valid`&&`move_ready`. `x_board` shows the new mark after that edge (E0).
- CHECK_X occupies E0→E1. THINK occupies AI_DELAY cycles.
- `o_board` updates at edge E(1+AI_DELAY). `move_ready` returns high after E(2+AI_DELAY).
- With AI_DELAY=2: O is committed at E3 and `move_ready`=1 after E4.
- `illegal` is registered: it is high for exactly the one cycle after the rejecting edge.
- Win/draw flags rise at the edge leaving CHECK_X or CHECK_O.
- `rst` asserted mid-THINK or mid-CHECK clears all state immediately, with no partial O commit.
- `gen_o` must be stable by the last THINK cycle. It is sampled only at that edge.

## Configuration
- `TTT_GAME_CTRL_O_FIRST_EN` defined:
  - After reset or `new_game`, the state is THINK and the computer moves first on the empty board.
  - `move_ready`=0 until the O commit and CHECK_O complete.
- Macro undefined: after reset or `new_game`, the state is WAIT_X and the human moves first.

## Test plan
- Reset, then `move_pos`=4 with `gen_o` driven by the real generator:
  - After reset: boards 0, `move_ready`=1.
  - After accept: `x_board`=9'h010. At E3, `o_board`=9'h001, `move_count`=2. `move_ready`=1 after E4.
- Illegal moves:
  - Replay `move_pos`=4 → `illegal` pulses for 1 cycle, boards unchanged.
  - `move_pos`=9 → `illegal` pulses, boards unchanged.
- X win, using a stubbed `gen_o` that keeps O away from the line:
  - X plays 0, 1, 2 → `x_win`=1, state DONE, `move_ready`=0.
  - A further `move_valid` → no `illegal` pulse.
- Draw:
  - Scripted moves fill the board with no line → `draw`=1, `move_count`=9.
  - Stub `gen_o`=`o_board` (no new mark) → `gen_err`=1, `o_board` unchanged.
- Reset and `new_game` interrupts:
  - `rst` pulsed in the second THINK cycle → boards 0, no O commit, WAIT_X.
  - `new_game` together with `move_valid` → move discarded, boards 0.
- Build with `TTT_GAME_CTRL_O_FIRST_EN`:
  - After reset, `move_ready`=0.
  - With the real generator: `o_board`=9'h010 after AI_DELAY cycles, then `move_ready`=1.
